// File: rtl/fp_pkg.sv
// Shared constants, FSM encoding and result-packing helpers for the FP normalizer.
// The optional single-cycle shifter is selected with FP_NORM_FAST_EN (see fp_normalize.sv).
package fp_pkg;

  localparam int FP_EXP_W   = 8;
  localparam int FP_FRAC_W  = 23;
  localparam int FP_EXP_MAX = 255;
  localparam int FP_BIAS    = 127;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } fp_state_e;

  typedef struct packed {
    logic [31:0] result;
    logic        neg;
    logic        zero;
    logic        carry;
    logic        overflow;
  } fp_out_t;

  // Exponent arrives two bits wider than the field so that both the adder
  // carry and an increment past 511 still register as overflow.
  function automatic fp_out_t fp_pack(input logic                  sign,
                                      input logic [FP_EXP_W+1:0]   exp,
                                      input logic [FP_FRAC_W-1:0]  frac,
                                      input logic                  carry);
    fp_out_t o;
    o.neg   = sign;
    o.zero  = 1'b0;
    o.carry = carry;
    if (int'(exp) >= FP_EXP_MAX) begin
      o.result   = {sign, {FP_EXP_W{1'b1}}, {FP_FRAC_W{1'b0}}};
      o.overflow = 1'b1;
    end else begin
      o.result   = {sign, exp[FP_EXP_W-1:0], frac};
      o.overflow = 1'b0;
    end
    return o;
  endfunction

  function automatic fp_out_t fp_flush(input logic sign);
    fp_out_t o;
    o.result   = {sign, 31'b0};
    o.neg      = 1'b0;
    o.zero     = 1'b1;
    o.carry    = 1'b0;
    o.overflow = 1'b0;
    return o;
  endfunction

endpackage

// File: rtl/fp_normalize_if.sv
// Handshake bundle between the adder datapath (master) and the normalizer (slave).
interface fp_normalize_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [8:0]  in_exp;
  logic [24:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        neg;
  logic        zero;
  logic        carry;
  logic        overflow;
  logic        busy;

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, result, neg, zero, carry, overflow, busy
  );

  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, result, neg, zero, carry, overflow, busy
  );
endinterface

// File: rtl/fp_lzc.sv
// 24-bit leading-zero counter; an all-zero input reports 24.
module fp_lzc (
  input  logic [23:0] value_i,
  output logic [4:0]  count_o
);
  // Scanning upward lets the most significant set bit win.
  always_comb begin
    count_o = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (value_i[i]) count_o = 5'(23 - i);
    end
  end
endmodule

// File: rtl/fp_normalize.sv
// Normalizes a raw adder result into packed IEEE-754 single plus condition flags.
// Define FP_NORM_FAST_EN for a one-cycle leading-zero shift instead of bit-serial shifting.
module fp_normalize
  import fp_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  fp_normalize_if.slave bus
);

  fp_state_e             state_q;
  logic                  sign_q;
  logic [FP_EXP_W:0]     exp_q;
  logic [FP_FRAC_W-1:0]  mant_q;
  fp_out_t               out_q;

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = out_q.result;
  assign bus.neg       = out_q.neg;
  assign bus.zero      = out_q.zero;
  assign bus.carry     = out_q.carry;
  assign bus.overflow  = out_q.overflow;

`ifdef FP_NORM_FAST_EN
  logic [4:0]           lz;
  logic [FP_FRAC_W-1:0] frac_fast;

  // Hidden bit is known clear in SHIFT, so the counter sees it as a leading zero.
  fp_lzc u_lzc (
    .value_i ({1'b0, mant_q}),
    .count_o (lz)
  );
  assign frac_fast = 23'({1'b0, mant_q} << lz);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      out_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            sign_q <= bus.in_sign;
            exp_q  <= bus.in_exp;
            mant_q <= bus.in_mant[FP_FRAC_W-1:0];
            if (bus.in_mant == '0) begin
              out_q   <= fp_flush(1'b0);
              state_q <= DONE;
            end else if (bus.in_mant[24]) begin
              out_q   <= fp_pack(bus.in_sign, {1'b0, bus.in_exp} + 10'd1,
                                 bus.in_mant[23:1], 1'b1);
              state_q <= DONE;
            end else if (bus.in_mant[23]) begin
              out_q   <= fp_pack(bus.in_sign, {1'b0, bus.in_exp},
                                 bus.in_mant[22:0], 1'b0);
              state_q <= DONE;
            end else if (bus.in_exp == '0) begin
              out_q   <= fp_flush(bus.in_sign);
              state_q <= DONE;
            end else begin
              state_q <= SHIFT;
            end
          end
        end

        SHIFT: begin
`ifdef FP_NORM_FAST_EN
          // Full shift fits only if the exponent stays at or above 1.
          if ({4'd0, lz} < exp_q) begin
            out_q <= fp_pack(sign_q, {1'b0, exp_q} - {5'd0, lz}, frac_fast, 1'b0);
          end else begin
            out_q <= fp_flush(sign_q);
          end
          state_q <= DONE;
`else
          if (exp_q == 9'd1) begin
            out_q   <= fp_flush(sign_q);
            state_q <= DONE;
          end else begin
            mant_q <= {mant_q[FP_FRAC_W-2:0], 1'b0};
            exp_q  <= exp_q - 9'd1;
            if (mant_q[FP_FRAC_W-1]) begin
              out_q   <= fp_pack(sign_q, {1'b0, exp_q} - 10'd1,
                                 {mant_q[FP_FRAC_W-2:0], 1'b0}, 1'b0);
              state_q <= DONE;
            end
          end
`endif
        end

        DONE: begin
          if (bus.out_ready) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalize.sv
// Scoreboard bench for fp_normalize: randomized raw results against an integer reference model.
`timescale 1ns/1ps
module tb_fp_normalize;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fp_normalize_if bus();

  fp_normalize dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] result;
    logic        neg;
    logic        zero;
    logic        carry;
    logic        ovf;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   hold = 0;
  bit   stall = 0;
  bit   force_rdy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic n, input logic z,
                              input logic c, input logic o, input int lat);
    exp_t x;
    x.result = r; x.neg = n; x.zero = z; x.carry = c; x.ovf = o; x.lat = lat; x.acc = 0;
    return x;
  endfunction

  // Reference: value-level normalization on plain integers.
  function automatic exp_t model(input logic s, input logic [8:0] e9, input logic [24:0] m25);
    exp_t r;
    int e, m, fe, fm, lz;
    bit flush, zs;
    e = int'(e9); m = int'(m25);
    r = mk(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    flush = 0; zs = s; fe = 0; fm = 0;
    if (m == 0) begin
      flush = 1; zs = 0;
    end else if (m >= 32'h1000000) begin
      fe = e + 1; fm = m >> 1; r.carry = 1'b1;
    end else if (m >= 32'h800000) begin
      fe = e; fm = m;
    end else if (e == 0) begin
      flush = 1;
    end else begin
      lz = 0;
      while (((m << lz) & 32'h800000) == 0) lz++;
      if (e - lz >= 1) begin
        fe = e - lz; fm = m << lz; r.lat = 1 + lz;
      end else begin
        flush = 1; r.lat = 1 + e;
      end
`ifdef FP_NORM_FAST_EN
      r.lat = 2;
`endif
    end
    if (flush) begin
      r.result = {zs, 31'b0}; r.zero = 1'b1;
    end else begin
      r.neg = s;
      if (fe >= 255) begin
        r.result = {s, 8'hFF, 23'b0}; r.ovf = 1'b1;
      end else begin
        r.result = {s, 8'(fe), 23'(fm)};
      end
    end
    return r;
  endfunction

  // Monitor: pops on the first out_valid cycle, then checks stability while held.
  always @(negedge clk) begin
    if (reset) begin
      hold = 0;
      bus.out_ready = 1'b0;
    end else begin
      if (bus.out_valid) begin
        if (!hold) begin
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_out_valid actual=%h required=none", bus.result);
            cur = mk(bus.result, bus.neg, bus.zero, bus.carry, bus.overflow, 0);
          end else begin
            cur = sb_q.pop_front();
            chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
            chk("result", bus.result, cur.result);
            chk("flags", {28'd0, bus.neg, bus.zero, bus.carry, bus.overflow},
                {28'd0, cur.neg, cur.zero, cur.carry, cur.ovf});
            $display("txn result=%h flags(nzco)=%b%b%b%b lat=%0d",
                     bus.result, bus.neg, bus.zero, bus.carry, bus.overflow, cyc - cur.acc);
          end
          hold = 1;
        end else begin
          chk("hold_result", bus.result, cur.result);
          chk("hold_flags", {28'd0, bus.neg, bus.zero, bus.carry, bus.overflow},
              {28'd0, cur.neg, cur.zero, cur.carry, cur.ovf});
        end
      end
      bus.out_ready = force_rdy ? 1'b1 : (stall ? 1'b0 : ($urandom_range(0, 3) != 0));
      if (bus.out_valid && bus.out_ready) hold = 0;
    end
  end

  // Junk with in_valid is driven while busy to confirm it is never captured.
  task automatic send(input logic s, input logic [8:0] e, input logic [24:0] m, input exp_t x);
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_sign  = 1'($urandom);
      bus.in_exp   = 9'($urandom);
      bus.in_mant  = 25'($urandom);
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout actual=0 required=1");
      bus.in_valid = 1'b0;
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_sign  = s;
    bus.in_exp   = e;
    bus.in_mant  = m;
    x.acc = cyc;
    sb_q.push_back(x);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
    chk({nm, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({nm, "_result"}, bus.result, 32'd0);
    chk({nm, "_flags"}, {28'd0, bus.neg, bus.zero, bus.carry, bus.overflow}, 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || hold) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0 || hold) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d required=0", sb_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sign  = 1'b0;
    bus.in_exp   = '0;
    bus.in_mant  = '0;
    bus.out_ready = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check_idle("reset");
    reset = 1'b0;
    @(negedge clk);

    // Directed cases with literal expectations.
    send(1'b0, 9'd127, 25'h0C00000, mk(32'h3FC00000, 0, 0, 0, 0, 1));
    send(1'b0, 9'd127, 25'h1800000, mk(32'h40400000, 0, 0, 1, 0, 1));
`ifdef FP_NORM_FAST_EN
    send(1'b0, 9'd130, 25'h0200000, mk(32'h40000000, 0, 0, 0, 0, 2));
    send(1'b1, 9'd3,   25'h0000100, mk(32'h80000000, 0, 1, 0, 0, 2));
`else
    send(1'b0, 9'd130, 25'h0200000, mk(32'h40000000, 0, 0, 0, 0, 3));
    send(1'b1, 9'd3,   25'h0000100, mk(32'h80000000, 0, 1, 0, 0, 4));
`endif
    send(1'b1, 9'd100, 25'h0000000, mk(32'h00000000, 0, 1, 0, 0, 1));
    send(1'b0, 9'd254, 25'h1000000, mk(32'h7F800000, 0, 0, 1, 1, 1));
    send(1'b1, 9'd0,   25'h0400000, mk(32'h80000000, 0, 1, 0, 0, 1));
    send(1'b1, 9'd300, 25'h0800000, mk(32'hFF800000, 1, 0, 0, 1, 1));
    drain();

    // Output held for five cycles must stay stable.
    stall = 1;
    send(1'b1, 9'd127, 25'h0C00000, mk(32'hBFC00000, 1, 0, 0, 0, 1));
    repeat (5) @(negedge clk);
    stall = 0;
    drain();

    // out_ready held high: exactly one out_valid per input.
    force_rdy = 1;
    send(1'b0, 9'd20, 25'h0000400, model(1'b0, 9'd20, 25'h0000400));
    send(1'b1, 9'd200, 25'h1FFFFFF, model(1'b1, 9'd200, 25'h1FFFFFF));
    send(1'b0, 9'd50, 25'h0900000, model(1'b0, 9'd50, 25'h0900000));
    repeat (30) @(negedge clk);
    force_rdy = 0;
    drain();

    // Reset while a result is pending in DONE.
    stall = 1;
    send(1'b0, 9'd127, 25'h1800000, mk(32'h40400000, 0, 0, 1, 0, 1));
    @(negedge clk);
    chk("done_out_valid", 32'(bus.out_valid), 32'd1);
    #2 reset = 1'b1;
    #1 check_idle("rst_done");
    sb_q.delete();
    hold = 0;
    @(negedge clk);
    reset = 1'b0;
    stall = 0;

    // Reset in the middle of a long shift.
    send(1'b1, 9'd130, 25'h0000001, model(1'b1, 9'd130, 25'h0000001));
    @(negedge clk);
    chk("shift_busy", 32'(bus.busy), 32'd1);
    chk("shift_in_ready", 32'(bus.in_ready), 32'd0);
    #2 reset = 1'b1;
    #1 check_idle("rst_shift");
    sb_q.delete();
    hold = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      logic        s;
      logic [8:0]  e;
      logic [24:0] m;
      int          k;
      s = 1'($urandom);
      case ($urandom_range(0, 9))
        0:       m = 25'h0;
        1, 2:    m = 25'h1000000 | 25'($urandom_range(0, 32'hFFFFFF));
        3:       m = 25'h0800000 | 25'($urandom_range(0, 32'h7FFFFF));
        default: begin
          k = $urandom_range(1, 23);
          m = 25'(1 << (23 - k)) | 25'($urandom & ((1 << (23 - k)) - 1));
        end
      endcase
      case ($urandom_range(0, 5))
        0:       e = 9'd0;
        1:       e = 9'($urandom_range(1, 24));
        2:       e = 9'($urandom_range(240, 511));
        default: e = 9'($urandom_range(1, 511));
      endcase
      send(s, e, m, model(s, e, m));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
